// File: rtl/ccc_pkg.sv
// Shared types and constants for the CCC lock monitor / reset sequencer.
//   ccc_state_e : sequencer FSM state encoding (also driven on the STATE port)
//   *_DEF       : default parameter values for ccc_lock_rst_seq
//   first_en()  : lowest enabled channel index at or above a start index
package ccc_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } ccc_state_e;

  localparam int unsigned N_CH_DEF            = 4;
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned LOCK_STABLE_CYC_DEF = 1024;
  localparam int unsigned RST_STEP_CYC_DEF    = 16;

  // Channel index space is sized for the largest supported N_CH; MAX_CH itself
  // is the "no channel found" code.
  localparam int unsigned     MAX_CH   = 16;
  localparam int unsigned     CH_IDX_W = 5;
  localparam logic [4:0]      NO_CH    = 5'd16;

  // Lowest set bit of mask with index >= start, or NO_CH if there is none.
  function automatic logic [CH_IDX_W-1:0] first_en(input logic [MAX_CH-1:0] mask,
                                                   input logic [CH_IDX_W-1:0] start);
    logic [CH_IDX_W-1:0] idx;
    idx = NO_CH;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (CH_IDX_W'(i) >= start)) idx = CH_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ccc_sync.sv
// Multi-bit flop synchroniser for quasi-static asynchronous inputs.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : asynchronous input bus (W bits)
//   q   : synchronised output, STAGES clock edges after d
module ccc_sync #(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  // Shift chain; stage 0 is the metastability-exposed flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/ccc_lock_rst_seq.sv
// Lock monitor and reset sequencer for N_CH fabric CCC instances.
// Synchronises each LOCK, waits for LOCK_STABLE_CYC consecutive all-locked
// cycles, then releases the per-domain resets one enabled channel every
// RST_STEP_CYC cycles. Any lock loss after qualification re-asserts all resets,
// records a sticky per-channel fault and restarts the sequence.
//   CLK         free-running clock
//   RESET       asynchronous active-high reset
//   LOCK_IN     raw CCC LOCK outputs (asynchronous)
//   CH_EN       channel enable mask (sampled while waiting for lock)
//   SOFT_RST    synchronous restart request, level
//   CLR_STICKY  clears LOSS_STICKY (and LOSS_CNT), single cycle
//   RST_N_OUT   per-domain active-low resets
//   ALL_LOCKED  high while every enabled channel is released and running
//   LOSS_STICKY per-channel lock-lost-after-qualification flags
//   STATE       current FSM state (ccc_pkg::ccc_state_e)
//   LOSS_CNT    saturating loss-event counter, present only with
//               LOCK_LOSS_CNT_EN defined
module ccc_lock_rst_seq
  import ccc_pkg::*;
#(
  parameter int unsigned N_CH            = N_CH_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
  parameter int unsigned RST_STEP_CYC    = RST_STEP_CYC_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] LOCK_IN,
  input  logic [N_CH-1:0] CH_EN,
  input  logic            SOFT_RST,
  input  logic            CLR_STICKY,
  output logic [N_CH-1:0] RST_N_OUT,
  output logic            ALL_LOCKED,
  output logic [N_CH-1:0] LOSS_STICKY,
  output logic [1:0]      STATE
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [7:0]      LOSS_CNT
`endif
);

  localparam int unsigned STAB_W = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
  localparam int unsigned STEP_W = (RST_STEP_CYC > 1) ? $clog2(RST_STEP_CYC) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RST_STEP_CYC - 1);

  ccc_state_e          state_q;
  logic [N_CH-1:0]     lock_s;
  logic [N_CH-1:0]     en_q;
  logic [N_CH-1:0]     rst_n_q;
  logic [N_CH-1:0]     sticky_q;
  logic                all_locked_q;
  logic [STAB_W-1:0]   stab_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [CH_IDX_W-1:0] ch_idx;

  logic [N_CH-1:0]     loss;
  logic [N_CH-1:0]     sticky_set;
  logic                any_loss;
  logic                all_ok;
  logic                in_rel_run;
  logic                loss_evt;
  logic [CH_IDX_W-1:0] rel_idx;
  logic [CH_IDX_W-1:0] nxt_idx;

  ccc_sync #(.W(N_CH), .STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (LOCK_IN),
    .q   (lock_s)
  );

  // Lock qualification against the latched enable mask.
  assign loss       = en_q & ~lock_s;
  assign any_loss   = |loss;
  assign all_ok     = (en_q != '0) && !any_loss;
  assign in_rel_run = (state_q == RELEASE) || (state_q == RUN);
  assign loss_evt   = in_rel_run && any_loss;
  assign sticky_set = in_rel_run ? loss : '0;

  // ch_idx is a search start: the channel released next is the first enabled
  // one at or above it, so disabled channels never consume a step.
  assign rel_idx = first_en(MAX_CH'(en_q), ch_idx);
  assign nxt_idx = first_en(MAX_CH'(en_q), rel_idx + CH_IDX_W'(1));

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= WAIT_LOCK;
      en_q         <= '0;
      rst_n_q      <= '0;
      sticky_q     <= '0;
      all_locked_q <= 1'b0;
      stab_cnt     <= '0;
      step_cnt     <= '0;
      ch_idx       <= '0;
    end else begin
      // A new loss wins over a same-cycle clear, bit by bit.
      sticky_q <= (CLR_STICKY ? '0 : sticky_q) | sticky_set;

      case (state_q)
        WAIT_LOCK: begin
          en_q         <= CH_EN;
          rst_n_q      <= '0;
          all_locked_q <= 1'b0;
          if (!SOFT_RST && all_ok) begin
            state_q  <= STABLE;
            stab_cnt <= '0;
          end
        end

        STABLE: begin
          if (SOFT_RST || any_loss) begin
            state_q <= WAIT_LOCK;
          end else if (stab_cnt == STAB_LAST) begin
            state_q  <= RELEASE;
            step_cnt <= '0;
            ch_idx   <= '0;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end

        RELEASE: begin
          if (SOFT_RST || any_loss) begin
            state_q      <= WAIT_LOCK;
            rst_n_q      <= '0;
            all_locked_q <= 1'b0;
          end else if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            ch_idx   <= rel_idx + CH_IDX_W'(1);
            for (int unsigned i = 0; i < N_CH; i++) begin
              if (CH_IDX_W'(i) == rel_idx) rst_n_q[i] <= 1'b1;
            end
            if (nxt_idx == NO_CH) begin
              state_q      <= RUN;
              all_locked_q <= 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + STEP_W'(1);
          end
        end

        RUN: begin
          if (SOFT_RST || any_loss) begin
            state_q      <= WAIT_LOCK;
            rst_n_q      <= '0;
            all_locked_q <= 1'b0;
          end
        end

        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;

  // Saturating loss counter; an increment wins over a same-cycle clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      loss_cnt_q <= '0;
    end else if (loss_evt) begin
      if (loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
    end else if (CLR_STICKY) begin
      loss_cnt_q <= '0;
    end
  end

  assign LOSS_CNT = loss_cnt_q;
`else
  logic unused_loss_evt;
  assign unused_loss_evt = loss_evt;
`endif

  assign RST_N_OUT   = rst_n_q;
  assign ALL_LOCKED  = all_locked_q;
  assign LOSS_STICKY = sticky_q;
  assign STATE       = state_q;

endmodule
